// File: rtl/rom_arbiter_pkg.sv
// Shared constants and types for the two-port instruction-ROM arbiter.
package rom_arbiter_pkg;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Owner of the single ROM access that is one cycle away from returning.
    typedef struct packed {
        logic valid;
        logic owner;
    } infl_t;

endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry response register: captures a ROM word and holds it until the consumer takes it.
module rom_rsp_slot
    import rom_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_cap_valid,
    input  logic [31:0] i_cap_data,
    input  logic        i_rsp_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data
);

    logic        r_valid;
    logic [31:0] r_data;

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            // NOTE: the data word is reset as well so it reads 0, not X, before the first capture.
            r_data  <= '0;
        end else if (i_cap_valid) begin
            r_valid <= 1'b1;
            r_data  <= i_cap_data;
        end else if (r_valid && i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_rsp_data  = r_data;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between fetch (I) and data-load (D) requesters.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req_valid,
    output logic          i_req_ready,
    input  logic [AW-1:0] i_req_addr,
    output logic          i_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   i_rsp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_req_addr,
    output logic          d_rsp_valid,
    input  logic          d_rsp_ready,
    output logic [31:0]   d_rsp_data,
    output logic          rom_rx_valid,
    output logic [31:0]   rom_rx_addr,
    input  logic          rom_tx_valid,
    input  logic [31:0]   rom_tx_data,
    output logic          err_spurious
);

    infl_t       r_infl;
    logic        r_last_grant;
    logic        r_err_spurious;
    logic        w_elig_i;
    logic        w_elig_d;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_grant_any;
    logic        w_grant_port;
    logic        w_cap_i;
    logic        w_cap_d;
    logic [31:0] w_addr_i;
    logic [31:0] w_addr_d;

    generate
        if (AW >= 32) begin : g_addr_trunc
            assign w_addr_i = i_req_addr[31:0];
            assign w_addr_d = d_req_addr[31:0];
        end else begin : g_addr_zext
            assign w_addr_i = {{(32-AW){1'b0}}, i_req_addr};
            assign w_addr_d = {{(32-AW){1'b0}}, d_req_addr};
        end
    endgenerate

    // A port may not issue while its own access is in flight or its response slot cannot drain.
    assign w_elig_i = i_req_valid & ~(r_infl.valid & (r_infl.owner == PORT_I))
                    & (~i_rsp_valid | i_rsp_ready);
    assign w_elig_d = d_req_valid & ~(r_infl.valid & (r_infl.owner == PORT_D))
                    & (~d_rsp_valid | d_rsp_ready);

    always_comb begin
        // NOTE: defaults first so no path leaves a grant unassigned (no latch).
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_elig_i && w_elig_d) begin
            if (PRIO_MODE == PRIO_FIXED || r_last_grant == PORT_D)
                w_grant_i = 1'b1;
            else
                w_grant_d = 1'b1;
        end else begin
            w_grant_i = w_elig_i;
            w_grant_d = w_elig_d;
        end
    end

    assign w_grant_any  = w_grant_i | w_grant_d;
    assign w_grant_port = w_grant_d ? PORT_D : PORT_I;

    assign i_req_ready  = w_grant_i;
    assign d_req_ready  = w_grant_d;
    assign rom_rx_valid = w_grant_any;
    assign rom_rx_addr  = w_grant_i ? w_addr_i : (w_grant_d ? w_addr_d : 32'h0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_infl         <= '{valid: 1'b0, owner: PORT_I};
            r_last_grant   <= PORT_D;
            r_err_spurious <= 1'b0;
        end else begin
            r_infl.valid <= w_grant_any;
            if (w_grant_any) begin
                r_infl.owner <= w_grant_port;
                r_last_grant <= w_grant_port;
            end
            if (rom_tx_valid && !r_infl.valid)
                r_err_spurious <= 1'b1;
        end
    end

    // A missing rom_tx_valid simply retires the in-flight entry without a capture.
    assign w_cap_i = rom_tx_valid & r_infl.valid & (r_infl.owner == PORT_I);
    assign w_cap_d = rom_tx_valid & r_infl.valid & (r_infl.owner == PORT_D);

    rom_rsp_slot u_slot_i (
        .clk         (clk),
        .rstn        (rstn),
        .i_cap_valid (w_cap_i),
        .i_cap_data  (rom_tx_data),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_valid (i_rsp_valid),
        .o_rsp_data  (i_rsp_data)
    );

    rom_rsp_slot u_slot_d (
        .clk         (clk),
        .rstn        (rstn),
        .i_cap_valid (w_cap_d),
        .i_cap_data  (rom_tx_data),
        .i_rsp_ready (d_rsp_ready),
        .o_rsp_valid (d_rsp_valid),
        .o_rsp_data  (d_rsp_data)
    );

    assign err_spurious = r_err_spurious;

endmodule
